frogger_game_ctrl: RTL
======================

Name: frogger_game_ctrl

Overview:
Game-flow sequencer for Frogger. It sits between the debounced switches, the VGA frame timing and frogger_game. It owns the top-level phase (attract, play, death pause, level-up pause, game over), plus lives, level and the BCD score that drives the two seven-segment digits. It tells the playfield datapath when to freeze and when to respawn the frog.

Parameters:
LIVES_INIT, 3, lives loaded at game start (1..3)
MAX_LEVEL, 9, level saturation value (1..15)
DEATH_FRAMES, 60, frames spent in DEATH pause (1..255)
LEVEL_FRAMES, 90, frames spent in LEVEL_UP pause (1..255)

Ports:
i_Clk  in  1  25 MHz pixel clock
i_Rst_L  in  1  asynchronous active-low reset
i_VSync  in  1  raw VSync from VGA_sync_pulses; high during active rows
i_Start  in  1  debounced start request (all four switches pressed)
i_Frog_Hit  in  1  one-cycle collision pulse from frogger_game
i_Frog_Home  in  1  one-cycle pulse when the frog reaches the top row
o_State  out  3  current state encoding
o_Freeze  out  1  1 = playfield objects must not move
o_Respawn  out  1  one-cycle pulse: reset frog to the start tile
o_Lives  out  2  remaining lives
o_Level  out  4  current level, 1..MAX_LEVEL
o_Score_Tens  out  4  BCD tens digit
o_Score_Ones  out  4  BCD ones digit

Behaviour:
- Reset (i_Rst_L low, asynchronous) forces:
  - State = IDLE, o_Freeze = 1, o_Respawn = 0.
  - o_Lives = LIVES_INIT, o_Level = 1, score = 00.
  - Frame timer = 0; edge-detect registers = 0.
- Frame tick: one-cycle internal pulse, registered one cycle after i_VSync is sampled falling (1 to 0).
- Start edge: i_Start sampled high when it was low the previous cycle. A held i_Start never re-triggers.
- States: IDLE=0, PLAY=1, DEATH=2, LEVEL_UP=3, GAME_OVER=4. Codes 5-7 are unreachable and decode to IDLE on the next cycle.
- IDLE:
  - On start edge go to PLAY.
  - Load lives = LIVES_INIT, level = 1, score = 00.
  - Pulse o_Respawn.
- PLAY:
  - i_Frog_Hit: if lives > 1, decrement lives, clear timer, go to DEATH. If lives == 1, set lives = 0 and go to GAME_OVER.
  - i_Frog_Home: BCD-increment the score (09→10; saturate at 99), clear timer, go to LEVEL_UP.
  - Hit and Home in the same cycle: Hit wins and the score is unchanged.
  - Start edge is ignored.
- DEATH:
  - Timer increments on each frame tick.
  - When timer == DEATH_FRAMES-1 and a tick occurs: go to PLAY and pulse o_Respawn.
- LEVEL_UP:
  - On entry, level increments, saturating at MAX_LEVEL.
  - Timer works as in DEATH, using LEVEL_FRAMES. Exit goes to PLAY and pulses o_Respawn.
- GAME_OVER:
  - Holds lives = 0, score and level.
  - Start edge goes to IDLE; score is kept until the next IDLE→PLAY.
- i_Frog_Hit and i_Frog_Home are ignored in every state except PLAY.
- o_Freeze = 1 in every state except PLAY. It is registered and updates on the same edge as o_State.
- o_Respawn is high for exactly one cycle, coincident with the first PLAY cycle.
- All outputs are registered; input-to-output latency is 1 cycle, except the frame tick path, which is 2 cycles from the VSync edge.
- Reset mid-pause aborts immediately to IDLE with no respawn pulse.

Decomposition:
- Shared header frogger_defs.vh:
  - state encodings;
  - widths (LIVES_W=2, LEVEL_W=4, BCD_W=4).
- One sub-module, frame_tick_gen:
  - inputs i_Clk, i_Rst_L, i_VSync;
  - output o_Tick;
  - contains the VSync synchroniser/edge detector.
- Score BCD logic and the FSM stay inline.

Test Plan:
- Reset, then i_Start high for 1000 cycles → exactly one o_Respawn pulse; State=1, Lives=3, Level=1, score 00, Freeze=0.
- In PLAY, pulse i_Frog_Hit → next cycle State=2, Lives=2, Freeze=1. After 60 VSync falls → State=1 with one o_Respawn pulse.
- Lives=1, pulse i_Frog_Hit → State=4, Lives=0. Hit/Home pulses are then ignored. Start edge → State=0; second start edge → Lives=3, score 00.
- Drive 12 Home events (each followed by 90 frames) → score 12, Level saturates at 9. Preload score 99, one more Home → score stays 99.
- Same-cycle i_Frog_Hit and i_Frog_Home in PLAY → State=2, score unchanged, Lives decremented by one.
- Assert i_Rst_L low at frame 30 of DEATH → immediately State=0, Freeze=1, Lives=3, no o_Respawn after release.

Source files
------------

// File: rtl/frogger_game_ctrl_pkg.sv
// Shared types and widths for the Frogger game-flow sequencer.
package frogger_game_ctrl_pkg;

  localparam int LIVES_W = 2;
  localparam int LEVEL_W = 4;
  localparam int BCD_W   = 4;
  localparam int TIMER_W = 8;

  // Phase encodings; codes 5..7 are never produced and fall back to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_DEATH     = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } score_t;

  // Two-digit BCD increment that sticks at 99.
  function automatic score_t bcd_inc_sat(input score_t s);
    score_t r;
    r = s;
    if (s.ones == 4'd9) begin
      if (s.tens != 4'd9) begin
        r.tens = s.tens + 4'd1;
        r.ones = 4'd0;
      end
    end else begin
      r.ones = s.ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/frogger_game_ctrl_if.sv
// Signal bundle between the switch/VGA/playfield side and the sequencer.
// Pulses (i_Start edge, i_Frog_Hit, i_Frog_Home) are single-cycle level
// samples on i_Clk; there is no backpressure, every output is registered and
// valid every cycle.
interface frogger_game_ctrl_if;
  import frogger_game_ctrl_pkg::*;

  logic               i_VSync;
  logic               i_Start;
  logic               i_Frog_Hit;
  logic               i_Frog_Home;
  logic [2:0]         o_State;
  logic               o_Freeze;
  logic               o_Respawn;
  logic [LIVES_W-1:0] o_Lives;
  logic [LEVEL_W-1:0] o_Level;
  logic [BCD_W-1:0]   o_Score_Tens;
  logic [BCD_W-1:0]   o_Score_Ones;

  modport master (
    output i_VSync, i_Start, i_Frog_Hit, i_Frog_Home,
    input  o_State, o_Freeze, o_Respawn, o_Lives, o_Level,
           o_Score_Tens, o_Score_Ones
  );

  modport slave (
    input  i_VSync, i_Start, i_Frog_Hit, i_Frog_Home,
    output o_State, o_Freeze, o_Respawn, o_Lives, o_Level,
           o_Score_Tens, o_Score_Ones
  );
endinterface

// File: rtl/frogger_game_ctrl_frame_tick.sv
// Turns the falling edge of VSync into a one-cycle frame tick.
module frame_tick_gen (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_VSync,
  output logic o_Tick
);

  logic vsync_q;
  logic tick_q;

  // Remember last VSync sample and register the 1->0 transition as the tick.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      vsync_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      vsync_q <= i_VSync;
      tick_q  <= vsync_q & ~i_VSync;
    end
  end

  assign o_Tick = tick_q;

endmodule

// File: rtl/frogger_game_ctrl.sv
// Frogger game-flow sequencer: phase FSM, lives, level and BCD score.
module frogger_game_ctrl
  import frogger_game_ctrl_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int MAX_LEVEL    = 9,
  parameter int DEATH_FRAMES = 60,
  parameter int LEVEL_FRAMES = 90
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  frogger_game_ctrl_if.slave bus
);

  localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);
  localparam logic [TIMER_W-1:0] DEATH_LAST = TIMER_W'(DEATH_FRAMES - 1);
  localparam logic [TIMER_W-1:0] LEVEL_LAST = TIMER_W'(LEVEL_FRAMES - 1);

  state_e             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  score_t             score_q, score_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               freeze_q, freeze_d;
  logic               respawn_q, respawn_d;
  logic               start_q;
  logic               start_edge;
  logic               tick;

  frame_tick_gen u_tick (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_VSync (bus.i_VSync),
    .o_Tick  (tick)
  );

  assign start_edge = bus.i_Start & ~start_q;

  // Phase sequencing and the game counters that move with it.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    level_d   = level_q;
    score_d   = score_q;
    timer_d   = timer_q;
    respawn_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d   = ST_PLAY;
          lives_d   = LIVES_LOAD;
          level_d   = LEVEL_W'(1);
          score_d   = '0;
          respawn_d = 1'b1;
        end
      end
      ST_PLAY: begin
        // A hit takes priority over reaching home in the same cycle.
        if (bus.i_Frog_Hit) begin
          timer_d = '0;
          if (lives_q > LIVES_W'(1)) begin
            lives_d = lives_q - LIVES_W'(1);
            state_d = ST_DEATH;
          end else begin
            lives_d = '0;
            state_d = ST_GAME_OVER;
          end
        end else if (bus.i_Frog_Home) begin
          score_d = bcd_inc_sat(score_q);
          timer_d = '0;
          state_d = ST_LEVEL_UP;
          if (level_q < LEVEL_MAX) level_d = level_q + LEVEL_W'(1);
        end
      end
      ST_DEATH: begin
        if (tick) begin
          if (timer_q == DEATH_LAST) begin
            state_d   = ST_PLAY;
            respawn_d = 1'b1;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end
      ST_LEVEL_UP: begin
        if (tick) begin
          if (timer_q == LEVEL_LAST) begin
            state_d   = ST_PLAY;
            respawn_d = 1'b1;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end
      ST_GAME_OVER: begin
        if (start_edge) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    freeze_d = (state_d != ST_PLAY);
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= ST_IDLE;
      lives_q   <= LIVES_LOAD;
      level_q   <= LEVEL_W'(1);
      score_q   <= '0;
      timer_q   <= '0;
      freeze_q  <= 1'b1;
      respawn_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      score_q   <= score_d;
      timer_q   <= timer_d;
      freeze_q  <= freeze_d;
      respawn_q <= respawn_d;
      start_q   <= bus.i_Start;
    end
  end

  assign bus.o_State      = state_q;
  assign bus.o_Freeze     = freeze_q;
  assign bus.o_Respawn    = respawn_q;
  assign bus.o_Lives      = lives_q;
  assign bus.o_Level      = level_q;
  assign bus.o_Score_Tens = score_q.tens;
  assign bus.o_Score_Ones = score_q.ones;

endmodule
